// File: rtl/id_ex_stage_pkg.sv
// Shared CPU pipeline definitions: control-bundle bit positions, widths and the NOP bundle.
// Used by id_ex_stage and its hazard logic.
package id_ex_stage_pkg;

  localparam int EX_W = 3;
  localparam int M_W  = 3;
  localparam int WB_W = 2;

  localparam int EX_REGDST  = 2;
  localparam int EX_ALUOP   = 1;
  localparam int EX_ALUSRC  = 0;
  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  typedef struct packed {
    logic [EX_W-1:0] ex;
    logic [M_W-1:0]  m;
    logic [WB_W-1:0] wb;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoded ID-stage fields in, registered EX-stage fields and
// upstream hold-enables out. The stage itself connects through the slave modport.
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;

  logic [EX_W-1:0] id_ex;
  logic [M_W-1:0]  id_m;
  logic [WB_W-1:0] id_wb;
  logic [31:0]     id_rd1, id_rd2, id_imm;
  logic [4:0]      id_rs, id_rt, id_rd;
  logic            id_valid;
  logic            flush;

  logic [EX_W-1:0] ex_ex;
  logic [M_W-1:0]  ex_m;
  logic [WB_W-1:0] ex_wb;
  logic [31:0]     ex_rd1, ex_rd2, ex_imm;
  logic [4:0]      ex_rs, ex_rt, ex_rd;
  logic            ex_valid;

  logic            pc_write;
  logic            ifid_write;
  logic            bubble;

  modport master (
    output id_ex, id_m, id_wb, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_valid, flush,
    input  ex_ex, ex_m, ex_wb, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_valid,
    input  pc_write, ifid_write, bubble
  );

  modport slave (
    input  id_ex, id_m, id_wb, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_valid, flush,
    output ex_ex, ex_m, ex_wb, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_valid,
    output pc_write, ifid_write, bubble
  );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: a valid load in EX whose destination (non-zero rt)
// is read by the valid instruction in ID.
module hazard_detect (
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_valid,
  output logic       load_use
);

  assign load_use = ex_valid && ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt)) && id_valid;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with one-cycle load-use stall and flush bubbling.
// Optional bubble counter port/logic enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [31:0]  bubble_cnt
`endif
);

  ctrl_t       r_ctrl;
  logic        r_valid;
  logic [31:0] r_rd1, r_rd2, r_imm;
  logic [4:0]  r_rs, r_rt, r_rd;

  logic        w_load_use;
  logic        w_kill;
  ctrl_t       w_ctrl_next;

  hazard_detect u_hazard_detect (
    .ex_valid   (r_valid),
    .ex_memread (r_ctrl.m[M_MEMREAD]),
    .ex_rt      (r_rt),
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .id_valid   (bus.id_valid),
    .load_use   (w_load_use)
  );

  // Flush outranks load-use, but both zero the control bundle identically.
  assign w_kill = bus.flush || w_load_use;

  // NOTE: default first so every path assigns w_ctrl_next and no latch is inferred.
  always_comb begin
    w_ctrl_next = CTRL_NOP;
    if (bus.id_valid && !w_kill) begin
      w_ctrl_next.ex = bus.id_ex;
      w_ctrl_next.m  = bus.id_m;
      w_ctrl_next.wb = bus.id_wb;
    end
  end

  // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl  <= CTRL_NOP;
      r_valid <= 1'b0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
    end else begin
      r_ctrl  <= w_ctrl_next;
      r_valid <= bus.id_valid && !w_kill;
      r_rd1   <= bus.id_rd1;
      r_rd2   <= bus.id_rd2;
      r_imm   <= bus.id_imm;
      r_rs    <= bus.id_rs;
      r_rt    <= bus.id_rt;
      r_rd    <= bus.id_rd;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_bubble_cnt <= '0;
    else if (w_kill) r_bubble_cnt <= r_bubble_cnt + 32'd1;
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

  assign bus.ex_ex      = r_ctrl.ex;
  assign bus.ex_m       = r_ctrl.m;
  assign bus.ex_wb      = r_ctrl.wb;
  assign bus.ex_valid   = r_valid;
  assign bus.ex_rd1     = r_rd1;
  assign bus.ex_rd2     = r_rd2;
  assign bus.ex_imm     = r_imm;
  assign bus.ex_rs      = r_rs;
  assign bus.ex_rt      = r_rt;
  assign bus.ex_rd      = r_rd;
  assign bus.pc_write   = !w_load_use;
  assign bus.ifid_write = !w_load_use;
  assign bus.bubble     = w_kill;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have ports id_ex, id_m, id_wb, inputs, 3/3/2 bits: decoded control bundles. EX={RegDst,ALUOp,ALUSrc}; M={Branch,MemRead,MemWrite}; WB={RegWrite,MemtoReg}.
REQ-004 SHALL have ports id_rd1, id_rd2, id_imm, inputs, 32 bits each: register-file read data and sign-extended immediate.
REQ-005 SHALL have ports id_rs, id_rt, id_rd, inputs, 5 bits each: instruction register specifiers.
REQ-006 SHALL have port id_valid, input, 1 bit: the ID stage holds a real instruction.
REQ-007 SHALL have port flush, input, 1 bit: branch taken downstream; discard the instruction in ID.
REQ-008 SHALL have outputs ex_ex, ex_m, ex_wb, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_valid: registered copies of the id_* inputs, with the same widths.
REQ-009 SHALL have outputs pc_write and ifid_write, 1 bit each: hold-enables to the upstream stages; active-high means advance.
REQ-010 SHALL have output bubble, 1 bit: a bubble is being inserted this cycle.
REQ-011 SHALL have output bubble_cnt, 32 bits, present only under the configuration macro.

Function
REQ-012 SHALL compute load_use combinationally as: ex_valid AND ex_m[1] (MemRead) AND ex_rt!=0 AND (ex_rt==id_rs OR ex_rt==id_rt) AND id_valid.
REQ-013 SHALL drive pc_write=ifid_write=~load_use, combinationally, in the same cycle.
REQ-014 SHALL drive bubble = load_use OR flush.
REQ-015 SHALL apply this per-edge priority: flush > load_use > normal capture.
REQ-016 SHALL, on flush or load_use, load ex_ex, ex_m, ex_wb and ex_valid with 0, while the data and specifier fields capture the id_* values as usual (don't-care).
REQ-017 SHALL, on a normal edge, capture every id_* field into its ex_* register; this gives a latency of exactly 1 cycle.
REQ-018 SHALL force the control fields to zero whenever id_valid=0, regardless of the id_ex/id_m/id_wb values.
REQ-019 SHALL limit any load-use stall to exactly one cycle: after the bubble, ex_valid=0, so load_use deasserts and the held instruction advances on the next edge.
REQ-020 SHALL, when flush and load_use are asserted together, insert one bubble, keep pc_write=0 for that cycle, and increment the counter once.
REQ-021 SHALL treat back-to-back loads as independent checks; each dependent consumer incurs its own one-cycle stall.

Reset
REQ-022 SHALL, on rst_n low and asynchronously, clear every ex_* register to 0, including ex_valid; bubble_cnt clears to 0 as well.
REQ-023 SHALL hold pc_write=ifid_write=1 and bubble=0 during reset, which follows from ex_valid=0 with flush low.
REQ-024 SHALL, when reset is asserted mid-stall, drop the stall immediately; the first post-reset edge performs a normal capture.

Configuration
REQ-025 SHALL, when macro ID_EX_BUBBLE_CNT_EN is defined, provide bubble_cnt: it increments by 1 on every edge with bubble=1, wraps from 0xFFFFFFFF to 0, and is cleared by reset.
REQ-026 SHALL, when ID_EX_BUBBLE_CNT_EN is undefined, omit both the bubble_cnt port and its logic; all other behaviour is identical.

Structure
REQ-027 SHALL place the following in the shared CPU package: bit-index constants for the EX/M/WB bundles (e.g. M_MEMREAD=1, EX_REGDST=2), bundle width constants (3/3/2), and a NOP control constant of all zeros.
REQ-028 SHALL implement the load-use detector as a sub-module named hazard_detect (ports ex_valid, ex_memread, ex_rt, id_rs, id_rt, id_valid -> load_use); the pipeline register stays in id_ex_stage.

Verification
REQ-029 Scenario 1: release reset, then drive an R-type with id_ex=110, id_wb=10 and id_rd1=0x5 -> one edge later ex_ex=110, ex_wb=10, ex_rd1=0x5, ex_valid=1, bubble=0.
REQ-030 Scenario 2: lw with rt=8 (id_m=010) followed by add with rs=8 -> the cycle after lw, pc_write=0, ifid_write=0, bubble=1; the next edge gives ex_ex/m/wb=0 and ex_valid=0; the edge after that holds the add in EX.
REQ-031 Scenario 3: lw with rt=0 followed by a consumer of rs=0 -> no stall, pc_write stays 1.
REQ-032 Scenario 4: assert flush for 1 cycle during an sw (id_m=001) -> ex_m=000, ex_valid=0, and pc_write stays 1.
REQ-033 Scenario 5: flush and load_use asserted together -> a single bubble, and bubble_cnt increments by exactly 1 under ID_EX_BUBBLE_CNT_EN.
REQ-034 Scenario 6: assert rst_n low asynchronously, mid-cycle, during a stall -> all ex_* outputs read 0 before the next clock edge and pc_write=1; with the macro, preset bubble_cnt to 0xFFFFFFFF, bubble once, and bubble_cnt reads 0.
